// File: rtl/chaotic_pkg.sv
// Shared definitions for the chaotic z-iteration controller: float64 exponent
// field location, controller states and error-flag bit positions.
package chaotic_pkg;

    localparam int          FP64_EXP_MSB  = 62;
    localparam int          FP64_EXP_LSB  = 52;
    localparam logic [10:0] FP64_EXP_ALL1 = 11'h7FF;

    localparam int ERR_NAN = 0;
    localparam int ERR_TMO = 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

endpackage

// File: rtl/chaotic_bit_fifo.sv
// Synchronous first-word-fall-through FIFO holding the extracted bit words.
// The head entry is always visible on data while empty is low.
module chaotic_bit_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] data,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_pop;
    logic             do_push;

    // A push into a full FIFO only lands when a pop frees the head slot in the same cycle.
    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
    end

    // Storage array, no reset needed since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign data  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));

    push_into_full: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));

endmodule

// File: rtl/chaotic_z_iter_ctrl.sv
// Iteration controller around the z-update stage: seeds z, issues one iterate at
// a time, feeds each result back as the next z, discards the warm-up transient
// and pushes B low mantissa bits of every kept iterate into an output FIFO.
module chaotic_z_iter_ctrl
    import chaotic_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int WARMUP     = 1000,
    parameter int B          = 8,
    parameter int LSB_OFS    = 0,
    parameter int FIFO_DEPTH = 16,
    parameter int TIMEOUT    = 512
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] seed_z,
    input  logic [15:0]           n_samples,
    output logic                  zn_valid,
    output logic [DATA_WIDTH-1:0] zn,
    input  logic                  zn1_valid,
    input  logic [DATA_WIDTH-1:0] zn1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [B-1:0]          out_data,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t        state;
    state_t        state_next;
    logic [31:0]   warm_cnt;
    logic [15:0]   keep_cnt;
    logic [TW-1:0] timer;

    logic          launch;
    logic          accept;
    logic          push;
    logic          nan_hit;
    logic          tmo_hit;
    logic          end_run;
    logic          exp_all1;
    logic          fifo_empty;
    logic          fifo_full;
    logic          fifo_pop;

    // State register; reset aborts any run in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-cycle control strobes.
    always_comb begin
        state_next = state;
        zn_valid   = 1'b0;
        launch     = 1'b0;
        accept     = 1'b0;
        push       = 1'b0;
        nan_hit    = 1'b0;
        tmo_hit    = 1'b0;
        end_run    = 1'b0;
        exp_all1   = (zn1[FP64_EXP_MSB:FP64_EXP_LSB] == FP64_EXP_ALL1);
        case (state)
            IDLE: begin
                if (start) begin
                    launch = 1'b1;
                    if (n_samples == 16'd0) begin
                        end_run = 1'b1;
                    end else begin
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE: begin
                // A kept iterate needs a free FIFO slot before it may be issued.
                if (!(warm_cnt == 32'd0 && fifo_full)) begin
                    zn_valid   = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (zn1_valid) begin
                    accept = 1'b1;
                    if (exp_all1) begin
                        nan_hit    = 1'b1;
                        end_run    = 1'b1;
                        state_next = IDLE;
                    end else if (warm_cnt != 32'd0) begin
                        state_next = ISSUE;
                    end else begin
                        push = 1'b1;
                        if (keep_cnt == 16'd1) begin
                            end_run    = 1'b1;
                            state_next = IDLE;
                        end else begin
                            state_next = ISSUE;
                        end
                    end
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    tmo_hit    = 1'b1;
                    end_run    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath registers: current z, phase counters, issue timer, sticky errors, done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            zn       <= '0;
            warm_cnt <= '0;
            keep_cnt <= '0;
            timer    <= '0;
            err      <= '0;
            done     <= 1'b0;
        end else begin
            done <= end_run;
            if (launch) begin
                zn       <= seed_z;
                warm_cnt <= 32'(WARMUP);
                keep_cnt <= n_samples;
                err      <= '0;
            end
            if (zn_valid) begin
                timer <= '0;
            end else if (state == WAIT) begin
                timer <= timer + TW'(1);
            end
            if (accept) begin
                zn <= zn1;
                if (!exp_all1 && warm_cnt != 32'd0) begin
                    warm_cnt <= warm_cnt - 32'd1;
                end
            end
            if (push) begin
                keep_cnt <= keep_cnt - 16'd1;
            end
            if (nan_hit) begin
                err[ERR_NAN] <= 1'b1;
            end
            if (tmo_hit) begin
                err[ERR_TMO] <= 1'b1;
            end
        end
    end

    assign busy      = (state != IDLE);
    assign out_valid = !fifo_empty;
    assign fifo_pop  = out_valid && out_ready;

    chaotic_bit_fifo #(
        .WIDTH (B),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (zn1[LSB_OFS+B-1:LSB_OFS]),
        .pop       (fifo_pop),
        .data      (out_data),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

endmodule

// File: tb/tb_chaotic_z_iter_ctrl.sv
// Scoreboard bench for chaotic_z_iter_ctrl with a fixed-latency z-stage stub.
// Stub step: tao*yn = 2^-40 * 2^-10 = 2^-50, i.e. 4 ulp inside [1,2), so iterate k
// of seed s has bit pattern s + 4k and its low byte is hand-computable.
module tb_chaotic_z_iter_ctrl;

    localparam int LAT = 244;
    localparam int TMO = 300;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] seed_z;
    logic [15:0] n_samples;
    logic        zn_valid;
    logic [63:0] zn;
    logic        zn1_valid;
    logic [63:0] zn1;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        busy;
    logic        done;
    logic [1:0]  err;

    int n_cmp = 0;
    int n_bad = 0;

    int edge_cnt = 0;
    int iss_cnt = 0;
    int done_cnt = 0;
    int nan_at = 0;
    bit drop = 1'b0;
    bit stray_req = 1'b0;
    int last_issue_edge = 0;
    int err_edge = 0;
    bit err_seen = 1'b0;

    logic [7:0]  exp_q [$];
    int          due_q [$];
    logic [63:0] res_q [$];

    chaotic_z_iter_ctrl #(
        .DATA_WIDTH (64),
        .WARMUP     (4),
        .B          (8),
        .LSB_OFS    (0),
        .FIFO_DEPTH (4),
        .TIMEOUT    (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .seed_z    (seed_z),
        .n_samples (n_samples),
        .zn_valid  (zn_valid),
        .zn        (zn),
        .zn1_valid (zn1_valid),
        .zn1       (zn1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [63:0] z_stage(input logic [63:0] z);
        real tao;
        real yn;
        tao = $bitstoreal(64'h3D70_0000_0000_0000);
        yn  = $bitstoreal(64'h3F50_0000_0000_0000);
        return $realtobits($bitstoreal(z) + tao * yn);
    endfunction

    // z-stage stub: capture issues, schedule results LAT cycles later
    initial begin
        logic [63:0] r;
        forever begin
            @(negedge clk);
            if (zn_valid) begin
                iss_cnt++;
                r = z_stage(zn);
                if (iss_cnt == nan_at) r = 64'h7FF8_0000_0000_0000;
                if (!drop) begin
                    due_q.push_back(edge_cnt + LAT);
                    res_q.push_back(r);
                end
            end
        end
    end

    // z-stage stub: result strobe driver (also injects stray strobes on request)
    initial begin
        zn1_valid = 1'b0;
        zn1 = '0;
        forever begin
            @(posedge clk);
            #1;
            zn1_valid = 1'b0;
            if (due_q.size() != 0 && due_q[0] == edge_cnt) begin
                zn1_valid = 1'b1;
                zn1 = res_q.pop_front();
                void'(due_q.pop_front());
            end else if (stray_req) begin
                zn1_valid = 1'b1;
                zn1 = 64'h4000_0000_0000_00AA;
                stray_req = 1'b0;
            end
        end
    end

    // Monitor: pop scoreboard on every accepted output word; track done and timing
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_out: got %0h expected none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", {56'd0, out_data}, {56'd0, e});
                end
            end
            if (done) done_cnt++;
            if (zn_valid) last_issue_edge = edge_cnt + 1;
            if (err[1] && !err_seen) begin
                err_seen = 1'b1;
                err_edge = edge_cnt;
            end
        end
    end

    task automatic do_start(input logic [63:0] s, input logic [15:0] n);
        @(posedge clk); #1;
        seed_z = s;
        n_samples = n;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check(name, {63'd0, busy}, 64'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_iss(input string name, input int n, input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (iss_cnt >= n) break;
        end
        check(name, 64'(iss_cnt), 64'(n));
    endtask

    task automatic drain(input string name);
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        @(posedge clk); #1;
        check({name, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
        check({name, "_out_valid"}, {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        int d0;
        rst = 1'b1;
        start = 1'b0;
        seed_z = '0;
        n_samples = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_zn_valid", {63'd0, zn_valid}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_err", {62'd0, err}, 64'd0);
        check("rst_zn", zn, 64'd0);

        // 1: basic run, 4 warm-up + 3 kept iterates
        iss_cnt = 0;
        d0 = done_cnt;
        exp_q.push_back(8'h15);
        exp_q.push_back(8'h19);
        exp_q.push_back(8'h1D);
        do_start(64'h3FF0_0000_0000_0001, 16'd3);
        check("t1_busy", {63'd0, busy}, 64'd1);
        wait_idle("t1_idle", 8 * (LAT + 10));
        check("t1_issues", 64'(iss_cnt), 64'd7);
        check("t1_done", 64'(done_cnt - d0), 64'd1);
        check("t1_err", {62'd0, err}, 64'd0);
        drain("t1");

        // 2: FIFO backpressure, stall after 4 pushes
        @(posedge clk); #1;
        out_ready = 1'b0;
        iss_cnt = 0;
        d0 = done_cnt;
        exp_q.push_back(8'h14); exp_q.push_back(8'h18); exp_q.push_back(8'h1C);
        exp_q.push_back(8'h20); exp_q.push_back(8'h24); exp_q.push_back(8'h28);
        do_start(64'h3FF0_0000_0000_0100, 16'd6);
        wait_iss("t2_reach8", 8, 9 * (LAT + 10));
        repeat (LAT + 100) @(negedge clk);
        check("t2_stall_issues", 64'(iss_cnt), 64'd8);
        check("t2_stall_busy", {63'd0, busy}, 64'd1);
        check("t2_stall_out_valid", {63'd0, out_valid}, 64'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_idle("t2_idle", 3 * (LAT + 10));
        check("t2_issues", 64'(iss_cnt), 64'd10);
        check("t2_done", 64'(done_cnt - d0), 64'd1);
        drain("t2");

        // 3: NaN on iterate 2
        iss_cnt = 0;
        nan_at = 2;
        d0 = done_cnt;
        do_start(64'h3FF0_0000_0000_0001, 16'd3);
        wait_idle("t3_idle", 3 * (LAT + 10));
        nan_at = 0;
        check("t3_err", {62'd0, err}, 64'd1);
        check("t3_issues", 64'(iss_cnt), 64'd2);
        check("t3_done", 64'(done_cnt - d0), 64'd1);
        check("t3_out_valid", {63'd0, out_valid}, 64'd0);

        // 4: dropped result -> timeout
        iss_cnt = 0;
        drop = 1'b1;
        err_seen = 1'b0;
        d0 = done_cnt;
        do_start(64'h3FF0_0000_0000_0001, 16'd3);
        check("t4_err_cleared", {62'd0, err}, 64'd0);
        wait_idle("t4_idle", TMO + 50);
        drop = 1'b0;
        check("t4_err", {62'd0, err}, 64'd2);
        check("t4_issues", 64'(iss_cnt), 64'd1);
        check("t4_tmo_cycles", 64'(err_edge - last_issue_edge), 64'(TMO));
        check("t4_done", 64'(done_cnt - d0), 64'd1);

        // 5: start while busy and stray result strobe during an ISSUE stall
        @(posedge clk); #1;
        out_ready = 1'b0;
        iss_cnt = 0;
        d0 = done_cnt;
        exp_q.push_back(8'h17); exp_q.push_back(8'h1B); exp_q.push_back(8'h1F);
        exp_q.push_back(8'h23); exp_q.push_back(8'h27); exp_q.push_back(8'h2B);
        do_start(64'h3FF8_0000_0000_0003, 16'd6);
        wait_iss("t5_reach1", 1, 20);
        repeat (10) @(posedge clk);
        do_start(64'h3FF0_0000_0000_0000, 16'd2);
        wait_iss("t5_reach8", 8, 9 * (LAT + 10));
        repeat (LAT + 20) @(negedge clk);
        @(posedge clk); #1;
        stray_req = 1'b1;
        do_start(64'h3FF0_0000_0000_0000, 16'd1);
        repeat (5) @(negedge clk);
        check("t5_stall_issues", 64'(iss_cnt), 64'd8);
        check("t5_stall_busy", {63'd0, busy}, 64'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_idle("t5_idle", 3 * (LAT + 10));
        check("t5_issues", 64'(iss_cnt), 64'd10);
        check("t5_done", 64'(done_cnt - d0), 64'd1);
        check("t5_err", {62'd0, err}, 64'd0);
        drain("t5");

        // 6: reset while waiting on a kept iterate; late result must be ignored
        iss_cnt = 0;
        d0 = done_cnt;
        do_start(64'h3FF0_0000_0000_0001, 16'd5);
        wait_iss("t6_reach5", 5, 6 * (LAT + 10));
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < LAT + 20; i++) begin
            @(negedge clk);
            if (due_q.size() == 0) break;
        end
        repeat (5) @(negedge clk);
        check("t6_stub_drained", 64'(due_q.size()), 64'd0);
        check("t6_busy", {63'd0, busy}, 64'd0);
        check("t6_out_valid", {63'd0, out_valid}, 64'd0);
        check("t6_zn", zn, 64'd0);
        check("t6_issues", 64'(iss_cnt), 64'd5);
        check("t6_done", 64'(done_cnt - d0), 64'd0);

        // n_samples == 0: no issue, done the cycle after start
        iss_cnt = 0;
        d0 = done_cnt;
        do_start(64'h3FF0_0000_0000_0001, 16'd0);
        check("n0_done_now", {63'd0, done}, 64'd1);
        check("n0_busy", {63'd0, busy}, 64'd0);
        repeat (5) @(negedge clk);
        check("n0_issues", 64'(iss_cnt), 64'd0);
        check("n0_done_cnt", 64'(done_cnt - d0), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #(10 * 60000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
